frame_capture_ctrl: RTL and testbench

//  Sequences the RGB565 pixel stream from the camera capture block into the downstream

---
 rtl/frame_capture_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_frame_capture_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_capture_ctrl.sv
// Frame capture sequencer: gates an RGB565 sync/valid pixel stream into whole frames with framing flags.
// Optional build macro CAPTURE_STATS_EN adds saturating captured/dropped frame counters.
module frame_capture_ctrl #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic              cfg_continuous,
    input  logic              cfg_stop,
    input  logic [3:0]        cfg_decim,
    output logic              busy,
    output logic              frame_done,
    output logic              err_short,
    output logic              err_long,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sync,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof
`ifdef CAPTURE_STATS_EN
    ,
    output logic [15:0]       stat_captured,
    output logic [15:0]       stat_dropped
`endif
);

    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOF,
        ACTIVE
    } state_t;

    state_t         state;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic [3:0]     skip_cnt;
    logic [3:0]     decim_q;
    logic           continuous_q;
    logic           stop_pend;
    logic           long_arm;

    logic           beat;
    logic           stopping;
    logic           frame_sync;
    logic           sync_take;
    logic           sync_skip;
    logic           frame_beat;
    logic           stray_beat;
    logic [XW-1:0]  px;
    logic [YW-1:0]  py;
    logic           at_eol;
    logic           at_eof;
    logic           eof_beat;

    assign in_ready = !out_valid || out_ready;
    assign busy     = (state != IDLE);

    // A sync seen in ACTIVE is handled exactly like one in WAIT_SOF, so both share
    // one decode; the sync-cycle beat is pixel (0,0) of the new frame.
    always_comb begin
        beat       = in_valid && in_ready;
        stopping   = cfg_stop || stop_pend;
        frame_sync = in_sync && ((state == ACTIVE) || ((state == WAIT_SOF) && !stopping));
        sync_take  = frame_sync && (skip_cnt == 4'd0);
        sync_skip  = frame_sync && (skip_cnt != 4'd0);
        frame_beat = beat && (sync_take || ((state == ACTIVE) && !in_sync));
        stray_beat = beat && long_arm && !in_sync && (state != ACTIVE);
        px         = in_sync ? '0 : x;
        py         = in_sync ? '0 : y;
        at_eol     = (px == X_LAST);
        at_eof     = at_eol && (py == Y_LAST);
        eof_beat   = frame_beat && at_eof;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            x            <= '0;
            y            <= '0;
            skip_cnt     <= '0;
            decim_q      <= '0;
            continuous_q <= 1'b0;
            stop_pend    <= 1'b0;
            long_arm     <= 1'b0;
            frame_done   <= 1'b0;
            err_short    <= 1'b0;
            err_long     <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_sof      <= 1'b0;
            out_eol      <= 1'b0;
            out_eof      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (in_sync)
                long_arm <= 1'b0;
            if (stray_beat)
                err_long <= 1'b1;

            if (frame_beat) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
                out_sof   <= (px == '0) && (py == '0);
                out_eol   <= at_eol;
                out_eof   <= at_eof;
                if (at_eol) begin
                    x <= '0;
                    y <= at_eof ? '0 : py + YW'(1);
                end else begin
                    x <= px + XW'(1);
                    y <= py;
                end
            end else if (sync_take) begin
                x <= '0;
                y <= '0;
            end

            if (sync_take)
                skip_cnt <= decim_q;
            else if (sync_skip)
                skip_cnt <= skip_cnt - 4'd1;

            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        state        <= WAIT_SOF;
                        err_short    <= 1'b0;
                        err_long     <= 1'b0;
                        skip_cnt     <= '0;
                        decim_q      <= cfg_decim;
                        continuous_q <= cfg_continuous;
                        stop_pend    <= 1'b0;
                    end
                end
                WAIT_SOF: begin
                    if (stopping) begin
                        state     <= IDLE;
                        stop_pend <= 1'b0;
                    end else if (sync_take) begin
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (cfg_stop)
                        stop_pend <= 1'b1;
                    if (in_sync) begin
                        err_short  <= 1'b1;
                        frame_done <= 1'b1;
                        if (sync_skip)
                            state <= WAIT_SOF;
                    end else if (eof_beat) begin
                        frame_done <= 1'b1;
                        long_arm   <= 1'b1;
                        if (continuous_q && !stopping) begin
                            state <= WAIT_SOF;
                        end else begin
                            state     <= IDLE;
                            stop_pend <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CAPTURE_STATS_EN
    logic [1:0]  drop_inc;
    logic [16:0] dropped_sum;

    // An aborted frame that is itself decimated counts twice: the short frame and the skipped sync.
    always_comb begin
        drop_inc    = {1'b0, (state == ACTIVE) && in_sync} + {1'b0, sync_skip};
        dropped_sum = {1'b0, stat_dropped} + 17'(drop_inc);
    end

    always_ff @(posedge clk) begin
        if (reset || ((state == IDLE) && cfg_start)) begin
            stat_captured <= '0;
            stat_dropped  <= '0;
        end else begin
            if (eof_beat && (stat_captured != 16'hFFFF))
                stat_captured <= stat_captured + 16'd1;
            stat_dropped <= dropped_sum[16] ? 16'hFFFF : dropped_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Scoreboard bench for frame_capture_ctrl at WIDTH=4, HEIGHT=2; stats checked when CAPTURE_STATS_EN is defined.
module tb_frame_capture_ctrl;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int DW   = 16;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_start;
    logic          cfg_continuous;
    logic          cfg_stop;
    logic [3:0]    cfg_decim;
    logic          busy;
    logic          frame_done;
    logic          err_short;
    logic          err_long;
    logic          in_valid;
    logic          in_ready;
    logic          in_sync;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_sof;
    logic          out_eol;
    logic          out_eof;
`ifdef CAPTURE_STATS_EN
    logic [15:0]   stat_captured;
    logic [15:0]   stat_dropped;
`endif

    frame_capture_ctrl #(.WIDTH(W), .HEIGHT(H), .DATA_W(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_start      (cfg_start),
        .cfg_continuous (cfg_continuous),
        .cfg_stop       (cfg_stop),
        .cfg_decim      (cfg_decim),
        .busy           (busy),
        .frame_done     (frame_done),
        .err_short      (err_short),
        .err_long       (err_long),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sync        (in_sync),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_sof        (out_sof),
        .out_eol        (out_eol),
        .out_eof        (out_eof)
`ifdef CAPTURE_STATS_EN
        ,
        .stat_captured  (stat_captured),
        .stat_dropped   (stat_dropped)
`endif
    );

    always #5 clk = ~clk;

    logic [18:0] exp_q[$];
    logic [18:0] exp_beat;
    logic [18:0] got_beat;
    logic [19:0] prev_out;
    logic        prev_stall = 1'b0;
    int          total  = 0;
    int          bad    = 0;
    int          fd_cnt = 0;
    int          or_mode = 0;

    // Output monitor: scoreboard pop, handshake rule, stall stability, frame_done count.
    always @(negedge clk) begin
        if (!reset) begin
            total++;
            if (in_ready !== (!out_valid || out_ready)) begin
                bad++;
                $display("[TB] FAIL in_ready_rule: got %b with out_valid=%b out_ready=%b", in_ready, out_valid, out_ready);
            end
            if (prev_stall) begin
                total++;
                if ({out_valid, out_data, out_sof, out_eol, out_eof} !== prev_out) begin
                    bad++;
                    $display("[TB] FAIL stall_hold: got %h required %h", {out_valid, out_data, out_sof, out_eol, out_eof}, prev_out);
                end
            end
            if (out_valid && out_ready) begin
                got_beat = {out_data, out_sof, out_eol, out_eof};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected_beat: got %h required none", got_beat);
                end else begin
                    exp_beat = exp_q.pop_front();
                    if (got_beat !== exp_beat) begin
                        bad++;
                        $display("[TB] FAIL beat: got data/sof/eol/eof %h required %h", got_beat, exp_beat);
                    end
                end
            end
            if (frame_done)
                fd_cnt++;
        end
        prev_stall = out_valid && !out_ready && !reset;
        prev_out   = {out_valid, out_data, out_sof, out_eol, out_eof};
    end

    task automatic step_cycle(input logic v, input logic s, input logic [DW-1:0] d, output logic acc);
        in_valid  = v;
        in_sync   = s;
        in_data   = d;
        out_ready = (or_mode == 0) ? 1'b1 : (or_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        #1;
        acc = v && in_ready;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        cfg_stop  = 1'b0;
        in_sync   = 1'b0;
    endtask

    task automatic send_pixel(input logic [DW-1:0] d, input logic s);
        logic acc;
        int   tries = 0;
        step_cycle(1'b1, s, d, acc);
        while (!acc && tries < 200) begin
            step_cycle(1'b1, 1'b0, d, acc);
            tries++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("[TB] FAIL pixel_accept: pixel %h not taken after %0d cycles, required accept", d, tries);
        end
        in_valid = 1'b0;
    endtask

    // Pushes expectations for the first NPIX pixels of a captured frame; stop_at pulses cfg_stop with that pixel.
    task automatic send_frame(input int npix, input logic [DW-1:0] base, input bit capture, input int stop_at);
        for (int i = 0; i < npix; i++) begin
            if (capture && i < NPIX)
                exp_q.push_back({DW'(base + i), i == 0, (i % W) == W - 1, i == NPIX - 1});
            if (i == stop_at)
                cfg_stop = 1'b1;
            send_pixel(DW'(base + i), i == 0);
        end
    endtask

    task automatic pulse_start(input logic cont, input logic [3:0] dec);
        logic acc;
        cfg_start      = 1'b1;
        cfg_continuous = cont;
        cfg_decim      = dec;
        step_cycle(1'b0, 1'b0, '0, acc);
    endtask

    task automatic pulse_stop();
        logic acc;
        cfg_stop = 1'b1;
        step_cycle(1'b0, 1'b0, '0, acc);
    endtask

    task automatic drain();
        logic acc;
        int   n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            step_cycle(1'b0, 1'b0, '0, acc);
            n++;
        end
        repeat (3) step_cycle(1'b0, 1'b0, '0, acc);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: %0d expected beats left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        logic acc;
        reset = 1'b1;
        step_cycle(1'b0, 1'b0, '0, acc);
        step_cycle(1'b0, 1'b0, '0, acc);
        @(negedge clk);
        total++; if (busy !== 1'b0)       begin bad++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
        total++; if (out_valid !== 1'b0)  begin bad++; $display("[TB] FAIL reset_out_valid: got %b required 0", out_valid); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_frame_done: got %b required 0", frame_done); end
        total++; if ({err_short, err_long} !== 2'b00) begin bad++; $display("[TB] FAIL reset_err: got %b required 00", {err_short, err_long}); end
        total++; if ({out_sof, out_eol, out_eof} !== 3'b000) begin bad++; $display("[TB] FAIL reset_flags: got %b required 000", {out_sof, out_eol, out_eof}); end
        total++; if (in_ready !== 1'b1)   begin bad++; $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready); end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_single_shot();
        int fd0 = fd_cnt;
        or_mode = 0;
        pulse_start(1'b0, 4'd0);
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL single_busy_armed: got %b required 1", busy); end
        send_frame(NPIX, 16'h0001, 1'b1, -1);
        @(negedge clk);
        total++; if (frame_done !== 1'b1) begin bad++; $display("[TB] FAIL single_done_timing: got %b required 1", frame_done); end
        total++; if ({out_valid, out_eof, out_data} !== {1'b1, 1'b1, 16'h0008}) begin
            bad++; $display("[TB] FAIL single_eof_beat: got v=%b eof=%b data=%h required 1 1 0008", out_valid, out_eof, out_data);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        total++; if (frame_done !== 1'b0) begin bad++; $display("[TB] FAIL single_done_pulse: got %b required 0", frame_done); end
        total++; if (busy !== 1'b0)       begin bad++; $display("[TB] FAIL single_busy_end: got %b required 0", busy); end
        @(posedge clk);
        #1;
        drain();
        total++; if (fd_cnt - fd0 != 1) begin bad++; $display("[TB] FAIL single_done_count: got %0d required 1", fd_cnt - fd0); end
        total++; if ({err_short, err_long} !== 2'b00) begin bad++; $display("[TB] FAIL single_err: got %b required 00", {err_short, err_long}); end
    endtask

    task automatic test_backpressure();
        int fd0 = fd_cnt;
        or_mode = 1;
        pulse_start(1'b0, 4'd0);
        send_frame(NPIX, 16'h0011, 1'b1, -1);
        drain();
        or_mode = 0;
        total++; if (fd_cnt - fd0 != 1) begin bad++; $display("[TB] FAIL bp_done_count: got %0d required 1", fd_cnt - fd0); end
        total++; if (busy !== 1'b0)     begin bad++; $display("[TB] FAIL bp_busy: got %b required 0", busy); end
    endtask

    task automatic test_decimation();
        logic acc;
        int   fd0 = fd_cnt;
        or_mode = 0;
        pulse_start(1'b1, 4'd2);
        for (int f = 0; f < 6; f++) begin
            send_frame(NPIX, 16'(16'h1000 + f * 16'h0100), (f == 0) || (f == 3), -1);
            step_cycle(1'b0, 1'b0, '0, acc);
        end
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL decim_busy_cont: got %b required 1", busy); end
        pulse_stop();
        drain();
        total++; if (fd_cnt - fd0 != 2) begin bad++; $display("[TB] FAIL decim_done_count: got %0d required 2", fd_cnt - fd0); end
        total++; if (busy !== 1'b0)     begin bad++; $display("[TB] FAIL decim_busy_stop: got %b required 0", busy); end
        total++; if ({err_short, err_long} !== 2'b00) begin bad++; $display("[TB] FAIL decim_err: got %b required 00", {err_short, err_long}); end
`ifdef CAPTURE_STATS_EN
        total++; if (stat_captured !== 16'd2) begin bad++; $display("[TB] FAIL stat_captured: got %0d required 2", stat_captured); end
        total++; if (stat_dropped !== 16'd4)  begin bad++; $display("[TB] FAIL stat_dropped: got %0d required 4", stat_dropped); end
`endif
    endtask

    task automatic test_short_frame();
        int fd0 = fd_cnt;
        or_mode = 0;
        pulse_start(1'b0, 4'd0);
        send_frame(5, 16'h2000, 1'b1, -1);
        send_frame(NPIX, 16'h2100, 1'b1, -1);
        drain();
        total++; if (err_short !== 1'b1) begin bad++; $display("[TB] FAIL short_err: got %b required 1", err_short); end
        total++; if (err_long !== 1'b0)  begin bad++; $display("[TB] FAIL short_err_long: got %b required 0", err_long); end
        total++; if (fd_cnt - fd0 != 2)  begin bad++; $display("[TB] FAIL short_done_count: got %0d required 2", fd_cnt - fd0); end
        total++; if (busy !== 1'b0)      begin bad++; $display("[TB] FAIL short_busy: got %b required 0", busy); end
    endtask

    task automatic test_long_frame();
        int fd0 = fd_cnt;
        or_mode = 0;
        pulse_start(1'b0, 4'd0);
        send_frame(10, 16'h3000, 1'b1, -1);
        drain();
        total++; if (err_long !== 1'b1)  begin bad++; $display("[TB] FAIL long_err: got %b required 1", err_long); end
        total++; if (err_short !== 1'b0) begin bad++; $display("[TB] FAIL long_err_short: got %b required 0", err_short); end
        total++; if (fd_cnt - fd0 != 1)  begin bad++; $display("[TB] FAIL long_done_count: got %0d required 1", fd_cnt - fd0); end
        pulse_start(1'b0, 4'd0);
        total++; if (err_long !== 1'b0)  begin bad++; $display("[TB] FAIL long_err_clear: got %b required 0", err_long); end
        send_frame(NPIX, 16'h3100, 1'b1, -1);
        drain();
        total++; if (err_long !== 1'b0)  begin bad++; $display("[TB] FAIL long_next_clean: got %b required 0", err_long); end
        total++; if (fd_cnt - fd0 != 2)  begin bad++; $display("[TB] FAIL long_next_done: got %0d required 2", fd_cnt - fd0); end
    endtask

    task automatic test_stop_reset();
        logic acc;
        int   fd0 = fd_cnt;
        or_mode = 0;
        pulse_start(1'b1, 4'd0);
        send_frame(NPIX, 16'h4000, 1'b1, 3);
        drain();
        total++; if (busy !== 1'b0)     begin bad++; $display("[TB] FAIL stop_busy: got %b required 0", busy); end
        total++; if (fd_cnt - fd0 != 1) begin bad++; $display("[TB] FAIL stop_done_count: got %0d required 1", fd_cnt - fd0); end
        send_frame(NPIX, 16'h4100, 1'b0, -1);
        drain();
        total++; if (busy !== 1'b0)     begin bad++; $display("[TB] FAIL idle_busy: got %b required 0", busy); end
        total++; if (err_long !== 1'b0) begin bad++; $display("[TB] FAIL idle_err_long: got %b required 0", err_long); end

        pulse_start(1'b0, 4'd0);
        or_mode = 2;
        step_cycle(1'b1, 1'b1, 16'h4200, acc);
        step_cycle(1'b1, 1'b1, 16'h4201, acc);
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (err_short !== 1'b1) begin bad++; $display("[TB] FAIL mid_err_short: got %b required 1", err_short); end
        total++; if ({out_valid, out_data} !== {1'b1, 16'h4200}) begin
            bad++; $display("[TB] FAIL mid_held_beat: got v=%b data=%h required 1 4200", out_valid, out_data);
        end
        total++; if (busy !== 1'b1)      begin bad++; $display("[TB] FAIL mid_busy: got %b required 1", busy); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_out_valid: got %b required 0", out_valid); end
        total++; if (busy !== 1'b0)      begin bad++; $display("[TB] FAIL rst_busy: got %b required 0", busy); end
        total++; if ({err_short, err_long} !== 2'b00) begin bad++; $display("[TB] FAIL rst_err: got %b required 00", {err_short, err_long}); end
        @(posedge clk);
        #1;
        reset     = 1'b0;
        or_mode   = 0;
        out_ready = 1'b1;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        cfg_start      = 1'b0;
        cfg_continuous = 1'b0;
        cfg_stop       = 1'b0;
        cfg_decim      = 4'd0;
        in_valid       = 1'b0;
        in_sync        = 1'b0;
        in_data        = '0;
        out_ready      = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_single_shot();
        test_backpressure();
        test_decimation();
        test_short_frame();
        test_long_frame();
        test_stop_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
